// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time after the synchronised reset,
// waiting for each domain's acknowledge and flagging a sticky fault on ack timeout.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          sync_reset,
  input  logic                          sw_restart,
  input  logic [NUM_STAGES-1:0]         stage_ack,
  output logic [NUM_STAGES-1:0]         rst_out,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
  output logic                          seq_done,
  output logic                          seq_fault,
  output logic [2:0]                    fsm_state
);

  localparam int STAGE_W = $clog2(NUM_STAGES);

  // One counter serves hold, gap and timeout, so it is sized for the largest.
  localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HG > TIMEOUT_CYCLES) ? CNT_MAX_HG : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_WAIT_ACK = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [STAGE_W-1:0] next_stage;
  logic               ack_cur;

  // Handshake: stage_ack is a level, not a pulse. Only bit cur_stage is looked at,
  // and only while waiting; a release is complete on the first edge it is seen high.
  assign ack_cur    = stage_ack[cur_stage];
  assign next_stage = cur_stage + 1'b1;
  assign fsm_state  = state;

  always_ff @(posedge clk) begin
    if (sync_reset || sw_restart) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      cur_stage <= '0;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      seq_fault <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            state      <= ST_WAIT_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_ACK: begin
          if (ack_cur) begin
            if (cur_stage == LAST_STAGE) begin
              seq_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              cnt   <= '0;
              state <= ST_GAP;
            end
          end else if (TIMEOUT_EN && (cnt == TO_LAST)) begin
            // cur_stage is left as-is so the failing domain stays visible.
            seq_fault <= 1'b1;
            rst_out   <= '1;
            state     <= ST_FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cur_stage           <= next_stage;
            rst_out[next_stage] <= 1'b0;
            cnt                 <= '0;
            state               <= ST_WAIT_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          rst_out  <= '0;
          seq_done <= 1'b1;
        end

        ST_FAULT: begin
          rst_out   <= '1;
          seq_fault <= 1'b1;
        end

        default: begin
          state     <= ST_HOLD;
          cnt       <= '0;
          cur_stage <= '0;
          rst_out   <= '1;
          seq_done  <= 1'b0;
          seq_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output words are queued as each
// stimulus step is driven and popped when the DUT output is sampled.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int W  = N + 2 + 2;

  logic         clk;
  logic         sync_reset;
  logic         sw_restart;
  logic [N-1:0] stage_ack;
  logic [N-1:0] rst_out;
  logic [1:0]   cur_stage;
  logic         seq_done;
  logic         seq_fault;
  logic [2:0]   fsm_state;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           now;

  reset_sequencer #(
    .NUM_STAGES    (4),
    .HOLD_CYCLES   (16),
    .GAP_CYCLES    (4),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .sw_restart(sw_restart),
    .stage_ack (stage_ack),
    .rst_out   (rst_out),
    .cur_stage (cur_stage),
    .seq_done  (seq_done),
    .seq_fault (seq_fault),
    .fsm_state (fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      now++;
    end
  endtask

  task automatic adv_to(input int target);
    if (target > now) tick(target - now);
  endtask

  // one edge with reset high; that edge becomes E0
  task automatic do_reset();
    sync_reset = 1'b1;
    tick(1);
    sync_reset = 1'b0;
    now = 0;
  endtask

  task automatic do_restart();
    sw_restart = 1'b1;
    tick(1);
    sw_restart = 1'b0;
    now = 0;
  endtask

  // scoreboard
  task automatic push_exp(input logic [N-1:0] r, input logic [1:0] s,
                          input logic d, input logic f);
    exp_q.push_back({r, s, d, f});
  endtask

  task automatic check_out(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected entry queued", tag);
      return;
    end
    exp_v = exp_q.pop_front();
    obs_v = {rst_out, cur_stage, seq_done, seq_fault};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed rst=%b stage=%0d done=%b fault=%b, expected rst=%b stage=%0d done=%b fault=%b",
             tag, obs_v[W-1 -: N], obs_v[3:2], obs_v[1], obs_v[0],
             exp_v[W-1 -: N], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic expect_at(input string tag, input int edge_n, input logic [N-1:0] r,
                           input logic [1:0] s, input logic d, input logic f);
    push_exp(r, s, d, f);
    adv_to(edge_n);
    check_out(tag);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    now        = 0;
    sync_reset = 1'b1;
    sw_restart = 1'b0;
    stage_ack  = 4'b1111;
    tick(3);

    // clean sequence
    do_reset();
    expect_at("reset_state",   0, 4'b1111, 2'd0, 1'b0, 1'b0);
    expect_at("clean_e15",    15, 4'b1111, 2'd0, 1'b0, 1'b0);
    expect_at("clean_e16",    16, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("clean_e20",    20, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("clean_e21",    21, 4'b1100, 2'd1, 1'b0, 1'b0);
    expect_at("clean_e26",    26, 4'b1000, 2'd2, 1'b0, 1'b0);
    expect_at("clean_e30",    30, 4'b1000, 2'd2, 1'b0, 1'b0);
    expect_at("clean_e31",    31, 4'b0000, 2'd3, 1'b0, 1'b0);
    expect_at("clean_e32",    32, 4'b0000, 2'd3, 1'b1, 1'b0);
    expect_at("clean_hold",   45, 4'b0000, 2'd3, 1'b1, 1'b0);

    // restart from DONE
    do_restart();
    expect_at("restart_done",  0, 4'b1111, 2'd0, 1'b0, 1'b0);
    expect_at("rsd_e16",      16, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("rsd_e32",      32, 4'b0000, 2'd3, 1'b1, 1'b0);

    // reset mid-sequence
    do_reset();
    adv_to(22);
    sync_reset = 1'b1;
    push_exp(4'b1111, 2'd0, 1'b0, 1'b0);
    tick(1);
    check_out("mid_reset");
    sync_reset = 1'b0;
    now = 0;
    expect_at("mid_e15",      15, 4'b1111, 2'd0, 1'b0, 1'b0);
    expect_at("mid_e16",      16, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("mid_e21",      21, 4'b1100, 2'd1, 1'b0, 1'b0);
    expect_at("mid_e32",      32, 4'b0000, 2'd3, 1'b1, 1'b0);

    // timeout on stage 1
    stage_ack = 4'b0001;
    do_reset();
    expect_at("to_e21",       21, 4'b1100, 2'd1, 1'b0, 1'b0);
    expect_at("to_e52",       52, 4'b1100, 2'd1, 1'b0, 1'b0);
    expect_at("to_e53",       53, 4'b1111, 2'd1, 1'b0, 1'b1);
    stage_ack = 4'b1111;
    expect_at("to_hold",     153, 4'b1111, 2'd1, 1'b0, 1'b1);

    // restart from FAULT
    do_restart();
    expect_at("restart_fault", 0, 4'b1111, 2'd0, 1'b0, 1'b0);
    expect_at("rsf_e16",      16, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("rsf_e32",      32, 4'b0000, 2'd3, 1'b1, 1'b0);

    // wrong-stage ack: stage 0 never acks
    stage_ack = 4'b1110;
    do_reset();
    expect_at("wrong_e16",    16, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("wrong_e30",    30, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("wrong_e47",    47, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("wrong_e48",    48, 4'b1111, 2'd0, 1'b0, 1'b1);

    // ack arrives on the timeout edge
    stage_ack = 4'b0000;
    do_reset();
    adv_to(47);
    stage_ack = 4'b0001;
    expect_at("ackto_e48",    48, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("ackto_e51",    51, 4'b1110, 2'd0, 1'b0, 1'b0);
    expect_at("ackto_e52",    52, 4'b1100, 2'd1, 1'b0, 1'b0);
    expect_at("ackto_nofault", 60, 4'b1100, 2'd1, 1'b0, 1'b0);

    // reset and restart together
    sync_reset = 1'b1;
    sw_restart = 1'b1;
    push_exp(4'b1111, 2'd0, 1'b0, 1'b0);
    tick(1);
    check_out("both_reset");
    sync_reset = 1'b0;
    sw_restart = 1'b0;
    now = 0;
    stage_ack = 4'($urandom_range(1, 15)) | 4'b0001;
    expect_at("both_e16",     16, 4'b1110, 2'd0, 1'b0, 1'b0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
